// File: rtl/reg_bank_if.sv
// Register bank access bundle: one write port, two read ports, stack pointer tap.
// Latency: n/a (wiring only).
// Backpressure: none; the control unit holds write signals stable around the clock edge.
interface reg_bank_if;
    logic        reg_write;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
    logic [4:0]  read_reg1;
    logic [4:0]  read_reg2;
    logic [31:0] read_data1;
    logic [31:0] read_data2;
    logic [31:0] sp_out;

    // Control side: drives write and read addresses, receives read data.
    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2,
        input  read_data1, read_data2, sp_out
    );

    // Register bank side.
    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2,
        output read_data1, read_data2, sp_out
    );
endinterface

// File: rtl/reg_bank.sv
// 32x32 general-purpose register bank: r0 hardwired to zero, stack pointer resets to SP_INIT.
// Latency: write lands on the next rising edge; reads are combinational, optional same-cycle bypass.
// Backpressure: none; writes are accepted every cycle, a write during reset is lost.
module reg_bank #(
    parameter int          SP_INDEX = 29,
    parameter logic [31:0] SP_INIT  = 32'd227,
    parameter bit          BYPASS   = 1'b1
) (
    input logic       clk,
    input logic       reset_n,
    reg_bank_if.slave bus
);

    localparam logic [4:0] SP_IDX = 5'(SP_INDEX);

    logic [31:0] regs_q [32];
    logic [31:0] regs_d [32];
    logic        wr_en;

    // A write to r0 is dropped here so r0 never holds anything but zero.
    assign wr_en = bus.reg_write && (bus.write_reg != 5'd0);

    // Next-state: copy of current contents with the addressed register replaced.
    always_comb begin
        regs_d = regs_q;
        if (wr_en) begin
            regs_d[bus.write_reg] = bus.write_data;
        end
        regs_d[0] = '0;
    end

    // Register storage; reset wins over any write presented in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == SP_INDEX) ? SP_INIT : 32'd0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    // Read port A: zero for r0, write-through when bypass hits, else stored value.
    always_comb begin
        bus.read_data1 = regs_q[bus.read_reg1];
        if (bus.read_reg1 == 5'd0) begin
            bus.read_data1 = '0;
        end else if (BYPASS && wr_en && (bus.write_reg == bus.read_reg1)) begin
            bus.read_data1 = bus.write_data;
        end
    end

    // Read port B: same rules as port A, fully independent.
    always_comb begin
        bus.read_data2 = regs_q[bus.read_reg2];
        if (bus.read_reg2 == 5'd0) begin
            bus.read_data2 = '0;
        end else if (BYPASS && wr_en && (bus.write_reg == bus.read_reg2)) begin
            bus.read_data2 = bus.write_data;
        end
    end

    // Stack pointer tap shows the stored value only, never the bypassed one.
    assign bus.sp_out = regs_q[SP_IDX];

endmodule
